// File: rtl/booth_multiplier_r4.sv
// Iterative radix-4 Booth multiplier with per-operation signed/unsigned mode.
// Each CALC cycle retires two multiplier bits. WIDTH must be even and at least 4.
module booth_multiplier_r4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic [2*WIDTH-1:0]   Z,
    output logic                 valid,
    output logic                 busy
);

    // Radix-4 steps per operation; derived, not overridable.
    localparam int unsigned ITER = WIDTH / 2 + 1;
    // Extended operand width (one guard bit pair so unsigned operands stay positive).
    localparam int unsigned XW   = WIDTH + 2;
    // Accumulator width; wide enough that +/-2*Xext never overflows.
    localparam int unsigned AW   = WIDTH + 4;
    localparam int unsigned CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [XW-1:0]        xext_q, xext_d;
    logic [XW-1:0]        mul_q, mul_d;
    logic                 ym1_q, ym1_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   z_q, z_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;

    logic [AW-1:0]        x_sx;
    logic [AW-1:0]        pp;
    logic [AW-1:0]        acc_sum;
    logic [AW-1:0]        acc_sh;
    logic [XW-1:0]        mul_sh;

    // Booth recoding of the current triplet and one accumulate/shift step.
    always_comb begin
        x_sx = {{2{xext_q[XW-1]}}, xext_q};
        pp   = '0;
        case ({mul_q[1:0], ym1_q})
            3'b001, 3'b010: pp = x_sx;
            3'b011:         pp = x_sx << 1;
            3'b100:         pp = AW'(-(x_sx << 1));
            3'b101, 3'b110: pp = AW'(-x_sx);
            default:        pp = '0;
        endcase
        acc_sum = acc_q + pp;
        acc_sh  = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
        mul_sh  = {acc_sum[1:0], mul_q[XW-1:2]};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        xext_d  = xext_q;
        mul_d   = mul_q;
        ym1_d   = ym1_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    xext_d  = signed_mode ? {{2{X[WIDTH-1]}}, X} : {2'b00, X};
                    mul_d   = signed_mode ? {{2{Y[WIDTH-1]}}, Y} : {2'b00, Y};
                    ym1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            CALC: begin
                acc_d = acc_sh;
                mul_d = mul_sh;
                ym1_d = mul_q[1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    // Product occupies {acc, mul}; keep its low 2*WIDTH bits.
                    z_d     = {acc_sh[WIDTH-3:0], mul_sh};
                    state_d = DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            xext_q  <= '0;
            mul_q   <= '0;
            ym1_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xext_q  <= xext_d;
            mul_q   <= mul_d;
            ym1_q   <= ym1_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign Z     = z_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_booth_multiplier_r4.sv
// Bench for booth_multiplier_r4: WIDTH=4 and WIDTH=8 instances, directed and random ops.
module tb_booth_multiplier_r4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, sm4, valid4, busy4;
    logic [3:0]  x4, y4;
    logic [7:0]  z4;
    logic        start8, sm8, valid8, busy8;
    logic [7:0]  x8, y8;
    logic [15:0] z8;

    int n_cmp = 0;
    int n_err = 0;

    booth_multiplier_r4 #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .X(x4), .Y(y4), .Z(z4), .valid(valid4), .busy(busy4)
    );

    booth_multiplier_r4 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .X(x8), .Y(y8), .Z(z8), .valid(valid8), .busy(busy8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain-arithmetic product of w-bit operands, truncated to 2*w bits.
    function automatic logic [15:0] ref_mul(input int w, input bit sm,
                                            input logic [7:0] x, input logic [7:0] y);
        longint xv, yv, p;
        xv = longint'(x);
        yv = longint'(y);
        if (sm && x[w-1]) xv = xv - (longint'(1) << w);
        if (sm && y[w-1]) yv = yv - (longint'(1) << w);
        p = (xv * yv) & ((longint'(1) << (2 * w)) - 1);
        return 16'(p);
    endfunction

    // One full operation on the selected instance with latency and result checks.
    task automatic op(input bit w8, input bit sm, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp, input string tag);
        int lat;
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; sm8 = sm; x8 = x; y8 = y;
        end else begin
            start4 = 1'b1; sm4 = sm; x4 = x[3:0]; y4 = y[3:0];
        end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start4 = 1'b0;
        // Scramble inputs after the accept edge; operands must already be latched.
        x8 = 8'($urandom); y8 = 8'($urandom); sm8 = 1'($urandom);
        x4 = 4'($urandom); y4 = 4'($urandom); sm4 = 1'($urandom);
        check({tag, "_busy"}, 32'(w8 ? busy8 : busy4), 32'd1);
        lat = 0;
        while (!(w8 ? valid8 : valid4) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), w8 ? 32'd5 : 32'd3);
        check({tag, "_z"}, w8 ? 32'(z8) : 32'(z4), 32'(exp));
        check({tag, "_nbusy"}, 32'(w8 ? busy8 : busy4), 32'd0);
    endtask

    logic [7:0]  leg_x [5] = '{8'h4, 8'hB, 8'hD, 8'h7, 8'h0};
    logic [7:0]  leg_y [5] = '{8'h3, 8'h2, 8'hD, 8'hC, 8'h0};
    logic [15:0] leg_z [5] = '{16'h0C, 16'hF6, 16'h09, 16'hE4, 16'h00};

    initial begin
        int lat;
        bit w8, sm;
        logic [7:0] rx, ry;
        rst = 1'b0;
        start4 = 0; sm4 = 0; x4 = 0; y4 = 0;
        start8 = 0; sm8 = 0; x8 = 0; y8 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_z8", 32'(z8), 32'd0);
        check("rst_v8", 32'(valid8), 32'd0);
        check("rst_b8", 32'(busy8), 32'd0);
        check("rst_z4", 32'(z4), 32'd0);
        check("rst_v4", 32'(valid4), 32'd0);
        check("rst_b4", 32'(busy4), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Legacy 4-bit signed vectors.
        for (int i = 0; i < 5; i++) op(1'b0, 1'b1, leg_x[i], leg_y[i], leg_z[i], "leg4");

        // 8-bit boundaries.
        op(1'b1, 1'b1, 8'h80, 8'h80, 16'h4000, "mneg_sq");
        op(1'b1, 1'b1, 8'h7F, 8'h80, 16'hC080, "max_mneg");
        op(1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "uones");
        op(1'b1, 1'b1, 8'hFF, 8'hFF, 16'h0001, "sones");
        op(1'b1, 1'b1, 8'h00, 8'h9C, 16'h0000, "zero_x");
        op(1'b1, 1'b0, 8'hAB, 8'h00, 16'h0000, "zero_y");
        op(1'b0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, "uones4");
        op(1'b0, 1'b1, 8'h08, 8'h08, 16'h0040, "mneg_sq4");

        // Start while busy is ignored.
        @(negedge clk);
        start8 = 1; sm8 = 0; x8 = 8'd6; y8 = 8'd7;
        @(posedge clk); #1; start8 = 0;
        @(posedge clk);
        @(negedge clk);
        start8 = 1; x8 = 8'd2; y8 = 8'd2;
        @(posedge clk); #1; start8 = 0;
        check("ign_busy", 32'(busy8), 32'd1);
        lat = 2;
        while (!valid8 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("ign_lat", 32'(lat), 32'd5);
        check("ign_z", 32'(z8), 32'd42);
        @(posedge clk); #1;
        check("ign_v", 32'(valid8), 32'd1);
        check("ign_b", 32'(busy8), 32'd0);

        // Back-to-back with start held high.
        @(negedge clk);
        start8 = 1; sm8 = 1; x8 = 8'd10; y8 = 8'd10;
        @(posedge clk); #1;
        x8 = 8'd3; y8 = 8'hFD;
        lat = 0;
        while (!valid8 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("b2b_lat1", 32'(lat), 32'd5);
        check("b2b_z1", 32'(z8), 32'd100);
        @(posedge clk); #1;
        start8 = 0;
        check("b2b_vfall", 32'(valid8), 32'd0);
        check("b2b_busy", 32'(busy8), 32'd1);
        lat = 0;
        while (!valid8 && lat < 20) begin
            check("b2b_hold", 32'(z8), 32'd100);
            @(posedge clk); #1; lat++;
        end
        check("b2b_lat2", 32'(lat), 32'd5);
        check("b2b_z2", 32'(z8), 32'hFFF7);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start8 = 1; sm8 = 0; x8 = 8'd100; y8 = 8'd100;
        @(posedge clk); #1; start8 = 0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("mrst_z", 32'(z8), 32'd0);
        check("mrst_v", 32'(valid8), 32'd0);
        check("mrst_b", 32'(busy8), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        op(1'b1, 1'b0, 8'd5, 8'd5, 16'd25, "post_rst");

        // Random operations on both widths against the arithmetic model.
        repeat (40) begin
            w8 = 1'($urandom);
            sm = 1'($urandom);
            rx = 8'($urandom);
            ry = 8'($urandom);
            if (!w8) begin rx = rx & 8'h0F; ry = ry & 8'h0F; end
            op(w8, sm, rx, ry, ref_mul(w8 ? 8 : 4, sm, rx, ry), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
